// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the UART
// transmitter and the uart_tx_arbiter.
interface uart_tx_arbiter_if;
    logic       req0_dav;
    logic [7:0] req0_data;
    logic       req0_ack;
    logic       req1_dav;
    logic [7:0] req1_data;
    logic       req1_ack;
    logic       tbre;
    logic [7:0] tdin;
    logic       wrn;
    logic       busy;
    logic       grant;
    logic       timeout_err;

    modport master (
        output req0_dav, req0_data,
        output req1_dav, req1_data,
        output tbre,
        input  req0_ack, req1_ack,
        input  tdin, wrn, busy,
        input  grant, timeout_err
    );

    modport slave (
        input  req0_dav, req0_data,
        input  req1_dav, req1_data,
        input  tbre,
        output req0_ack, req1_ack,
        output tdin, wrn, busy,
        output grant, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding two byte sources into one UART TX.
// Define UART_TX_ARBITER_TIMEOUT_EN to enable the tbre watchdog.
module uart_tx_arbiter #(
    parameter int STROBE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic             genclk,
    input logic             rst,
    uart_tx_arbiter_if.slave bus
);

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("STROBE_CYCLES out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_to
        $error("TIMEOUT_CYCLES out of range 1..1023");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);

    state_t     state;
    logic [3:0] scnt;
    logic       any_req;
    logic       pick1;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        any_req = bus.req0_dav | bus.req1_dav;
        pick1   = bus.req1_dav & (~bus.req0_dav | ~bus.grant);
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT_CYCLES);
    logic [9:0] wd;
    logic [9:0] wd_nxt;
    logic       in_wait;

    always_comb begin
        wd_nxt  = wd + 10'd1;
        in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
    end
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge genclk) begin
        if (!rst) begin
            state        <= IDLE;
            scnt         <= '0;
            bus.wrn      <= 1'b1;
            bus.tdin     <= 8'h00;
            bus.req0_ack <= 1'b0;
            bus.req1_ack <= 1'b0;
            bus.busy     <= 1'b0;
            bus.grant    <= 1'b1;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            wd              <= '0;
            bus.timeout_err <= 1'b0;
`endif
        end else begin
            bus.req0_ack <= 1'b0;
            bus.req1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.tbre && any_req) begin
                        state        <= LOAD;
                        bus.busy     <= 1'b1;
                        bus.grant    <= pick1;
                        bus.req0_ack <= ~pick1;
                        bus.req1_ack <= pick1;
                        bus.tdin     <= pick1 ? bus.req1_data
                                              : bus.req0_data;
                    end
                end
                LOAD: begin
                    state   <= STROBE;
                    bus.wrn <= 1'b0;
                    scnt    <= '0;
                end
                STROBE: begin
                    if (scnt == STB_LAST) begin
                        bus.wrn <= 1'b1;
                        state   <= WAIT_BUSY;
                    end else begin
                        scnt <= scnt + 4'd1;
                    end
                end
                WAIT_BUSY: begin
                    if (!bus.tbre) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.tbre) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            // Counter is held at zero outside the wait states.
            if (in_wait) begin
                wd <= wd_nxt;
                if (wd_nxt == WD_LIMIT) begin
                    bus.timeout_err <= 1'b1;
                    state           <= IDLE;
                    bus.busy        <= 1'b0;
                end
            end else begin
                wd <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// Watchdog expectations follow UART_TX_ARBITER_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    logic genclk = 1'b0;
    logic rst    = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .STROBE_CYCLES (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .genclk(genclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 genclk = ~genclk;

    task automatic chk(input string tag, input int got,
                       input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge genclk);
        #1;
    endtask

    // Wait for the strobe to finish, then emulate the UART
    // going busy and back to ready.
    task automatic finish_xfer();
        bit low_seen = 0;
        bit done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            step();
            if (bus.wrn == 1'b0) low_seen = 1;
            else if (low_seen) done = 1;
        end
        chk("strobe_done", int'(done), 1);
        bus.tbre = 1'b0;
        step();
        bus.tbre = 1'b1;
        step();
    endtask

    task automatic do_byte(output int who, output int d);
        who = -1;
        d   = -1;
        for (int i = 0; i < 10 && who < 0; i++) begin
            step();
            if (bus.req0_ack && bus.req1_ack) who = 2;
            else if (bus.req0_ack) who = 0;
            else if (bus.req1_ack) who = 1;
            if (who >= 0) d = int'(bus.tdin);
        end
        finish_xfer();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    int who, d, acks;
    int exp_who[4] = '{0, 1, 0, 1};
    int exp_d[4]   = '{'h11, 'h22, 'h11, 'h22};

    initial begin
        bus.req0_dav  = 1'b0;
        bus.req0_data = 8'h00;
        bus.req1_dav  = 1'b0;
        bus.req1_data = 8'h00;
        bus.tbre      = 1'b1;

        do_reset();
        chk("rst_wrn",  int'(bus.wrn), 1);
        chk("rst_tdin", int'(bus.tdin), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_grant", int'(bus.grant), 1);
        chk("rst_ack0", int'(bus.req0_ack), 0);
        chk("rst_ack1", int'(bus.req1_ack), 0);
        chk("rst_terr", int'(bus.timeout_err), 0);

        // Single request
        bus.req0_dav  = 1'b1;
        bus.req0_data = 8'hA5;
        step();
        chk("s_ack0", int'(bus.req0_ack), 1);
        chk("s_ack1", int'(bus.req1_ack), 0);
        chk("s_tdin", int'(bus.tdin), 'hA5);
        chk("s_grant", int'(bus.grant), 0);
        chk("s_wrn_load", int'(bus.wrn), 1);
        bus.req0_dav = 1'b0;
        step();
        chk("s_wrn_lo1", int'(bus.wrn), 0);
        chk("s_ack0_off", int'(bus.req0_ack), 0);
        step();
        chk("s_wrn_lo2", int'(bus.wrn), 0);
        chk("s_tdin_hold", int'(bus.tdin), 'hA5);
        step();
        chk("s_wrn_hi", int'(bus.wrn), 1);
        chk("s_busy_wb", int'(bus.busy), 1);
        bus.tbre = 1'b0;
        step();
        chk("s_busy_wd", int'(bus.busy), 1);
        chk("s_tdin_wd", int'(bus.tdin), 'hA5);
        bus.tbre = 1'b1;
        step();
        chk("s_busy_end", int'(bus.busy), 0);

        // Contention
        do_reset();
        bus.req0_dav  = 1'b1;
        bus.req0_data = 8'h11;
        bus.req1_dav  = 1'b1;
        bus.req1_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            do_byte(who, d);
            chk($sformatf("c_who%0d", k), who, exp_who[k]);
            chk($sformatf("c_dat%0d", k), d, exp_d[k]);
        end
        bus.req0_dav = 1'b0;
        bus.req1_dav = 1'b0;

        // Not ready
        bus.tbre      = 1'b0;
        bus.req1_dav  = 1'b1;
        bus.req1_data = 8'h5A;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            acks += int'(bus.req0_ack) + int'(bus.req1_ack);
        end
        chk("nr_acks", acks, 0);
        chk("nr_wrn", int'(bus.wrn), 1);
        chk("nr_busy", int'(bus.busy), 0);
        bus.tbre = 1'b1;
        step();
        chk("nr_ack1", int'(bus.req1_ack), 1);
        chk("nr_tdin", int'(bus.tdin), 'h5A);
        bus.req1_dav = 1'b0;
        finish_xfer();

        // Reset mid-transfer
        bus.req0_dav  = 1'b1;
        bus.req0_data = 8'h3C;
        step();
        chk("r_ack0", int'(bus.req0_ack), 1);
        bus.req0_dav = 1'b0;
        step();
        chk("r_strobe", int'(bus.wrn), 0);
        rst = 1'b0;
        step();
        chk("r_wrn", int'(bus.wrn), 1);
        chk("r_tdin", int'(bus.tdin), 0);
        chk("r_busy", int'(bus.busy), 0);
        chk("r_grant", int'(bus.grant), 1);
        rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            acks += int'(bus.req0_ack) + int'(bus.req1_ack);
            acks += int'(!bus.wrn);
        end
        chk("r_quiet", acks, 0);
        bus.req0_dav  = 1'b1;
        bus.req0_data = 8'h77;
        bus.req1_dav  = 1'b1;
        bus.req1_data = 8'h88;
        do_byte(who, d);
        bus.req0_dav = 1'b0;
        bus.req1_dav = 1'b0;
        chk("r_tie_who", who, 0);
        chk("r_tie_dat", d, 'h77);

        // Watchdog
        bus.req0_dav  = 1'b1;
        bus.req0_data = 8'h99;
        step();
        chk("w_ack0", int'(bus.req0_ack), 1);
        bus.req0_dav = 1'b0;
        step();
        step();
        step();
        chk("w_enter", int'(bus.wrn), 1);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        chk("w_pre_err", int'(bus.timeout_err), 0);
        chk("w_pre_busy", int'(bus.busy), 1);
        step();
        chk("w_err", int'(bus.timeout_err), 1);
        chk("w_idle", int'(bus.busy), 0);
`else
        for (int i = 0; i < 20; i++) step();
        chk("w_err_off", int'(bus.timeout_err), 0);
        chk("w_busy_off", int'(bus.busy), 1);
`endif
        bus.tbre = 1'b0;
        step();
        bus.tbre = 1'b1;
        step();
        chk("w_recover", int'(bus.busy), 0);

        // Early withdraw
        bus.tbre      = 1'b0;
        bus.req0_dav  = 1'b1;
        bus.req0_data = 8'hEE;
        step();
        bus.req0_dav = 1'b0;
        step();
        bus.tbre = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            acks += int'(bus.req0_ack) + int'(bus.req1_ack);
        end
        chk("e_no_ack", acks, 0);
        chk("e_busy", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Mutual exclusion of acks, sampled between edges.
    always @(negedge genclk) begin
        if (rst && bus.req0_ack && bus.req1_ack) begin
            n_fail++;
            $display("FAIL ack_excl: got both acks expected one");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- STROBE_CYCLES, 2, wrn low-pulse width in genclk cycles, legal range 1..15.
- TIMEOUT_CYCLES, 1023, tbre watchdog limit in cycles, legal range 1..1023.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- genclk, in, 1: the only clock; all logic on posedge.
- rst, in, 1: reset, synchronous, active-low.
- req0_dav, in, 1: requester 0 has a byte (10K TX buffer path).
- req0_data, in, 8: requester 0 byte.
- req0_ack, out, 1: one-cycle acceptance pulse to requester 0.
- req1_dav, in, 1: requester 1 has a byte (status/echo path).
- req1_data, in, 8: requester 1 byte.
- req1_ack, out, 1: one-cycle acceptance pulse to requester 1.
- tbre, in, 1: UART transmit buffer register empty, 1 = ready.
- tdin, out, 8: byte to the UART transmitter.
- wrn, out, 1: UART write strobe, active-low; the transmitter latches on its rising edge.
- busy, out, 1: high in every state except IDLE.
- grant, out, 1: index of the last granted requester.
- timeout_err, out, 1: sticky watchdog flag.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, STROBE, WAIT_BUSY and WAIT_DONE, all registered on posedge genclk.

REQ-004 IDLE: with tbre=1 and at least one dav high, the block SHALL select a requester and go to LOAD next cycle. With tbre=0, it SHALL stay in IDLE.

REQ-005 Selection SHALL work as follows:
- A single requester wins.
- If both dav are high, the requester not equal to grant wins (round-robin).

REQ-006 LOAD (exactly 1 cycle) SHALL:
- register tdin from the selected data;
- update grant;
- pulse the selected ack high for this cycle only;
- then go to STROBE.

REQ-007 STROBE SHALL hold wrn=0 for exactly STROBE_CYCLES cycles, then drive wrn=1 and go to WAIT_BUSY. tdin SHALL stay stable from LOAD through WAIT_DONE.

REQ-008 WAIT_BUSY: tbre=0 SHALL move the FSM to WAIT_DONE. WAIT_DONE: tbre=1 SHALL move the FSM to IDLE.

REQ-009 Latency: if dav is sampled high in IDLE at edge N, ack SHALL be high in cycle N+1 and wrn SHALL be low in cycles N+2..N+1+STROBE_CYCLES.

REQ-010 Each requester SHALL hold dav and data stable until its ack. If dav drops before the grant, the request SHALL be dropped with no ack. A dav change after LOAD SHALL have no effect on the current transfer.

REQ-011 If dav stays high after ack, it SHALL be treated as a new byte that is eligible at the next IDLE.

REQ-012 At most one ack SHALL be high in any cycle. An ack SHALL never be asserted outside LOAD.

REQ-013 If tbre goes to 1 in the same cycle that dav rises while the FSM is in WAIT_DONE, the FSM SHALL return to IDLE first. The grant SHALL be decided in IDLE on the next edge; no state is skipped.

REQ-014 Under continuous contention, the requesters SHALL alternate strictly (0,1,0,1,...).

Reset
REQ-015 When rst=0 at a posedge, the block SHALL set:
- state = IDLE, wrn = 1, tdin = 8'h00;
- req0_ack = req1_ack = 0;
- busy = 0, grant = 1 (so requester 0 wins the first tie);
- timeout_err = 0;
- watchdog counter = 0.

REQ-016 A reset during LOAD, STROBE or WAIT_* SHALL abandon the transfer. wrn SHALL be 1 from the next edge, and no further ack SHALL be issued for that byte.

Configuration
REQ-017 With macro UART_TX_ARBITER_TIMEOUT_EN defined:
- A 10-bit counter SHALL clear on entry to WAIT_BUSY and count every cycle spent in WAIT_BUSY and WAIT_DONE.
- When the counter reaches TIMEOUT_CYCLES, the block SHALL set timeout_err=1 (sticky; cleared only by reset) and go to IDLE.

REQ-018 Without the macro, the block SHALL have no counter, SHALL tie timeout_err to 0, and SHALL wait on tbre indefinitely.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single request: after reset, req0_dav=1, data=8'hA5, tbre=1 -> req0_ack high in cycle 1; tdin=8'hA5; wrn low for 2 cycles; busy until tbre 0->1.
- Contention: both dav high with data 8'h11/8'h22 for 4 bytes -> ack order 0,1,0,1; tdin sequence 11,22,11,22.
- Not ready: tbre=0 with req1_dav=1 for 10 cycles -> no ack, wrn=1, busy=0; tbre=1 -> req1_ack in the next cycle.
- Reset mid-transfer: rst=0 during STROBE cycle 1 -> next edge wrn=1, tdin=00, busy=0, no ack; first tie after reset goes to requester 0.
- Watchdog (macro on, TIMEOUT_CYCLES=16): tbre held 1 after the strobe -> timeout_err=1 exactly 16 cycles after entering WAIT_BUSY, FSM in IDLE; macro off -> busy stays 1 and timeout_err=0.
- Early withdraw: req0_dav pulses high for 1 cycle while tbre=0 -> no req0_ack ever.
